stopwatch_ctrl: RTL and testbench

Front-end controller for the 4-digit mm:ss stopwatch datapath. Takes three raw push-buttons (start, pause, clear) and conditions each one: synchronise, debounce, rising-edge detect. A small FSM turns the conditioned presses into the level signals `start_stop` and `pause` that the stopwatch consumes. It also produces a display blink enable while paused, and a forced-clear sequence.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_ctrl_btn_conditioner.sv | 78 +++++++
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch front end and datapath.
//   S_IDLE/S_RUN/S_PAUSE/S_CLEAR : FSM state encodings, also used by the datapath.
//   CLK_FREQ_DEFAULT             : default system clock frequency in Hz.
//   cnt_width()                  : width of a counter spanning 0..n-1 (never below 1).
package stopwatch_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_CLEAR = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// btn_conditioner: turns one raw asynchronous push-button into a one-cycle
// press pulse: 2-flop synchroniser, optional debounce, rising-edge detect.
// Build option: STOPWATCH_CTRL_DEBOUNCE_EN -- when defined the synchronised
// level must differ from the debounced level for DEBOUNCE_CYCLES consecutive
// cycles before it is accepted; when undefined the synchroniser output is used
// directly and DEBOUNCE_CYCLES has no effect.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset
//   i_btn   raw button, asynchronous, active-high
//   o_rise  one-cycle pulse on each accepted press
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_prev;
  logic w_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Any cycle where the synced input agrees with the accepted level restarts
  // the stability count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  localparam int unsigned DEBOUNCE_CYCLES_UNUSED = DEBOUNCE_CYCLES;

  assign w_level = r_sync2;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level_prev <= 1'b0;
    end else begin
      r_level_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_level_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end for the mm:ss stopwatch. Conditions the
// start/pause/clear buttons and runs the IDLE/RUN/PAUSE/CLEAR FSM that drives
// the stopwatch run and pause levels, the pause blink and a timed clear.
// Build option: STOPWATCH_CTRL_DEBOUNCE_EN enables button debouncing
// (see btn_conditioner).
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_start  raw start/stop button (async, active-high)
//   btn_pause  raw pause/resume button (async, active-high)
//   btn_clear  raw clear button (async, active-high)
//   start_stop run-enable level to the stopwatch
//   pause      pause level to the stopwatch
//   blink      display enable, 1 = digits on
//   state_o    current FSM state
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = CLK_FREQ_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000,
  parameter int unsigned CLEAR_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  output logic       start_stop,
  output logic       pause,
  output logic       blink,
  output logic [1:0] state_o
);

  // Clock frequency only documents how the cycle counts were derived.
  localparam int unsigned CLK_FREQ_UNUSED = CLK_FREQ;

  localparam int unsigned CLR_W = cnt_width(CLEAR_CYCLES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam int unsigned BLK_W = cnt_width(BLINK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic             w_start_rise;
  logic             w_pause_rise;
  logic             w_clear_rise;
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (btn_start),
    .o_rise(w_start_rise)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (btn_pause),
    .o_rise(w_pause_rise)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (btn_clear),
    .o_rise(w_clear_rise)
  );

  // Press priority clear > start > pause; losing presses are dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_clear_rise)      w_state_next = S_CLEAR;
        else if (w_start_rise) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_clear_rise)      w_state_next = S_CLEAR;
        else if (w_start_rise) w_state_next = S_IDLE;
        else if (w_pause_rise) w_state_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_clear_rise)      w_state_next = S_CLEAR;
        else if (w_start_rise) w_state_next = S_IDLE;
        else if (w_pause_rise) w_state_next = S_RUN;
      end
      S_CLEAR: begin
        if (r_clr_cnt == CLR_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR && r_clr_cnt != CLR_LAST) r_clr_cnt <= r_clr_cnt + 1'b1;
      else                                             r_clr_cnt <= '0;
    end
  end

  // Counting only while staying in PAUSE makes both the entry cycle and the
  // exit cycle show blink = 1 with the counter freshly at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (r_state != S_PAUSE || w_state_next != S_PAUSE) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (r_blk_cnt == BLK_LAST) begin
      r_blk_cnt <= '0;
      r_blink   <= ~r_blink;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign state_o    = r_state;
  assign start_stop = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign pause      = (r_state == S_PAUSE);
  assign blink      = r_blink;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with short debounce/blink/clear
// timings. Works with STOPWATCH_CTRL_DEBOUNCE_EN either defined or not.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 3;
  localparam int CLR = 2;
  localparam int HL  = DEB + 3;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam bit DEB_EN    = 1'b1;
  localparam int PRESS_LAT = 2 + DEB + 1;
`else
  localparam bit DEB_EN    = 1'b0;
  localparam int PRESS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_start = 1'b0;
  logic       b_pause = 1'b0;
  logic       b_clear = 1'b0;
  logic       start_stop;
  logic       pause;
  logic       blink;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CLK_FREQ       (50_000_000),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLK),
    .CLEAR_CYCLES   (CLR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (b_start),
    .btn_pause (b_pause),
    .btn_clear (b_clear),
    .start_stop(start_stop),
    .pause     (pause),
    .blink     (blink),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: modes, time-since-pause-entry, remaining clear cycles,
  // and per-button history of raw samples taken at each clock edge.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_CLEAR} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_clear_left = 0;
  int    m_pause_age = 0;
  bit    m_hist[3][HL];
  bit    m_deb[3];
  bit    m_deb_prev[3];

  function automatic logic [4:0] outs();
    return {state_o, start_stop, pause, blink};
  endfunction

  function automatic logic [4:0] model_outs();
    logic [1:0] c;
    logic ss, p, bl;
    case (m_mode)
      M_RUN:   begin c = 2'b01; ss = 1'b1; p = 1'b0; end
      M_PAUSE: begin c = 2'b10; ss = 1'b1; p = 1'b1; end
      M_CLEAR: begin c = 2'b11; ss = 1'b0; p = 1'b0; end
      default: begin c = 2'b00; ss = 1'b0; p = 1'b0; end
    endcase
    bl = (m_mode != M_PAUSE) || (((m_pause_age / BLK) % 2) == 0);
    return {c, ss, p, bl};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] want,
                     input logic [4:0] mask);
    checks++;
    if ((act & mask) !== (want & mask)) begin
      errors++;
      $display("FAIL %s t=%0t: got state=%b ss=%b pause=%b blink=%b, want state=%b ss=%b pause=%b blink=%b (mask %b)",
               name, $time, act[4:3], act[2], act[1], act[0], want[4:3], want[2], want[1], want[0], mask);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic step();
    bit    raw[3];
    bit    rise[3];
    bit    nd[3];
    bit    do_rst;
    mode_t nm;
    int    ncl;
    int    npa;
    raw[0] = b_start;
    raw[1] = b_pause;
    raw[2] = b_clear;
    do_rst = rst;
    for (int b = 0; b < 3; b++) begin
      bit flip;
      if (DEB_EN) rise[b] = m_deb[b] && !m_deb_prev[b];
      else        rise[b] = m_hist[b][1] && !m_hist[b][2];
      // Accept a new level once the last DEB synchronised samples all disagree.
      flip = 1'b1;
      for (int i = 1; i <= DEB; i++) if (m_hist[b][i] == m_deb[b]) flip = 1'b0;
      nd[b] = (DEB_EN && flip) ? !m_deb[b] : m_deb[b];
    end
    nm  = m_mode;
    ncl = m_clear_left;
    if (m_mode == M_CLEAR) begin
      ncl = m_clear_left - 1;
      if (ncl == 0) nm = M_IDLE;
    end else if (rise[2]) begin
      nm  = M_CLEAR;
      ncl = CLR;
    end else if (rise[0]) begin
      nm = (m_mode == M_IDLE) ? M_RUN : M_IDLE;
    end else if (rise[1] && m_mode != M_IDLE) begin
      nm = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    npa = (nm == M_PAUSE && m_mode == M_PAUSE) ? m_pause_age + 1 : 0;

    @(posedge clk);
    #1;
    if (do_rst) begin
      m_mode = M_IDLE;
      m_clear_left = 0;
      m_pause_age = 0;
      for (int b = 0; b < 3; b++) begin
        m_deb[b] = 1'b0;
        m_deb_prev[b] = 1'b0;
        for (int i = 0; i < HL; i++) m_hist[b][i] = 1'b0;
      end
    end else begin
      m_mode = nm;
      m_clear_left = ncl;
      m_pause_age = npa;
      for (int b = 0; b < 3; b++) begin
        m_deb_prev[b] = m_deb[b];
        m_deb[b] = nd[b];
        for (int i = HL - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = raw[b];
      end
    end
    chk("model", outs(), model_outs(), 5'b11111);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input logic [2:0] v);
    b_start = v[0];
    b_pause = v[1];
    b_clear = v[2];
  endtask

  typedef struct {
    logic [2:0] btn;   // {clear, pause, start}
    logic [4:0] want;  // {state, start_stop, pause, blink}; blink masked off
  } vec_t;

  localparam logic [4:0] O_IDLE  = 5'b00_0_0_1;
  localparam logic [4:0] O_RUN   = 5'b01_1_0_1;
  localparam logic [4:0] O_PAUSE = 5'b10_1_1_1;
  localparam logic [4:0] O_CLEAR = 5'b11_0_0_1;
  localparam logic [4:0] M_ALL   = 5'b11111;
  localparam logic [4:0] M_NOBLK = 5'b11110;

  vec_t tbl[16];
  bit   bseq[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b001, O_RUN};
    tbl[1]  = '{3'b010, O_PAUSE};
    tbl[2]  = '{3'b010, O_RUN};
    tbl[3]  = '{3'b010, O_PAUSE};
    tbl[4]  = '{3'b001, O_IDLE};
    tbl[5]  = '{3'b010, O_IDLE};
    tbl[6]  = '{3'b001, O_RUN};
    tbl[7]  = '{3'b100, O_IDLE};
    tbl[8]  = '{3'b101, O_IDLE};
    tbl[9]  = '{3'b001, O_RUN};
    tbl[10] = '{3'b011, O_IDLE};
    tbl[11] = '{3'b001, O_RUN};
    tbl[12] = '{3'b110, O_IDLE};
    tbl[13] = '{3'b001, O_RUN};
    tbl[14] = '{3'b010, O_PAUSE};
    tbl[15] = '{3'b011, O_IDLE};
    bseq = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

    // Reset, then quiet buttons.
    rst = 1'b1;
    set_btn(3'b000);
    steps(3);
    chk("reset", outs(), O_IDLE, M_ALL);
    rst = 1'b0;
    steps(20);
    chk("reset_stable", outs(), O_IDLE, M_ALL);

    // Table: press, release, check settled state.
    for (int i = 0; i < 16; i++) begin
      set_btn(tbl[i].btn);
      steps(12);
      set_btn(3'b000);
      steps(12);
      chk($sformatf("table[%0d]", i), outs(), tbl[i].want, M_NOBLK);
    end

    // Bouncing start press, RUN exactly PRESS_LAT cycles after the last rise.
    b_start = 1'b1; step();
    b_start = 1'b0; step();
    b_start = 1'b1; step();
    b_start = 1'b0; step();
    b_start = 1'b1;
    steps(PRESS_LAT - 1);
    chk("bounce_before", outs(), O_IDLE, M_ALL);
    step();
    chk("bounce_run", outs(), O_RUN, M_ALL);
    b_start = 1'b0;
    steps(12);
    b_start = 1'b1;
    steps(PRESS_LAT - 1);
    chk("restart_before", outs(), O_RUN, M_ALL);
    step();
    chk("restart_idle", outs(), O_IDLE, M_ALL);
    b_start = 1'b0;
    steps(12);

    // Pause and blink cadence.
    b_start = 1'b1;
    steps(PRESS_LAT);
    chk("run_again", outs(), O_RUN, M_ALL);
    b_start = 1'b0;
    steps(12);
    b_pause = 1'b1;
    steps(PRESS_LAT);
    chk("pause_entry", outs(), O_PAUSE, M_NOBLK);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) b_pause = 1'b0;
      chk($sformatf("blink[%0d]", i), {4'b0000, blink}, {4'b0000, bseq[i]}, 5'b00001);
      step();
    end
    b_pause = 1'b1;
    steps(PRESS_LAT);
    chk("resume", outs(), O_RUN, M_ALL);
    b_pause = 1'b0;
    steps(12);

    // Start and clear together from RUN; pause press lands inside CLEAR.
    set_btn(3'b101);
    step();
    b_pause = 1'b1;
    steps(PRESS_LAT - 1);
    chk("prio_clear0", outs(), O_CLEAR, M_ALL);
    step();
    chk("prio_clear1", outs(), O_CLEAR, M_ALL);
    step();
    chk("clear_done", outs(), O_IDLE, M_ALL);
    steps(5);
    chk("clear_after", outs(), O_IDLE, M_ALL);
    set_btn(3'b000);
    steps(12);

    // Reset in PAUSE with blink low; start held through reset starts the watch.
    b_start = 1'b1;
    steps(PRESS_LAT);
    b_start = 1'b0;
    steps(12);
    b_pause = 1'b1;
    steps(PRESS_LAT);
    b_pause = 1'b0;
    begin
      int n = 0;
      while (blink !== 1'b0 && n < 4 * BLK) begin
        step();
        n++;
      end
    end
    chk("pause_blink_low", outs(), 5'b10_1_1_0, M_ALL);
    rst = 1'b1;
    b_start = 1'b1;
    step();
    chk("mid_reset", outs(), O_IDLE, M_ALL);
    rst = 1'b0;
    steps(PRESS_LAT - 1);
    chk("held_start_before", outs(), O_IDLE, M_ALL);
    step();
    chk("held_start_run", outs(), O_RUN, M_ALL);
    b_start = 1'b0;
    steps(12);

    // Single-cycle glitch on pause while running.
    b_pause = 1'b1;
    step();
    b_pause = 1'b0;
    steps(2);
    chk("glitch_pause", outs(), DEB_EN ? O_RUN : O_PAUSE, M_NOBLK);
    steps(12);
    chk("glitch_settled", outs(), DEB_EN ? O_RUN : O_PAUSE, M_NOBLK);

    // Random buttons and occasional resets against the model.
    for (int seg = 0; seg < 30; seg++) begin
      int rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 20);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(rate - 1) == 0) b_start = ~b_start;
        if ($urandom_range(rate - 1) == 0) b_pause = ~b_pause;
        if ($urandom_range(rate - 1) == 0) b_clear = ~b_clear;
        rst = ($urandom_range(299) == 0);
        step();
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
